// File: rtl/contador_updown_param_pkg.sv
// Shared constants for the parametrised up/down counter: mode encodings and
// the helper that computes the default terminal count from the width.
package contador_updown_param_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int default_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/contador_updown_param_detector_flanco.sv
// Two-flop synchroniser followed by a delay flop; emits a one-clock pulse on
// each rising edge of an asynchronous input such as a board push-button.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s3 lags r_s2 by one clock, so a held input yields exactly one pulse.
    assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/contador_updown_param.sv
// Parametrised up/down modulo counter with load, enable, wrap/saturate mode and
// carry/borrow pulses for cascading; optional edge detection on up/down.
module contador_updown_param
    import contador_updown_param_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX       = default_max(WIDTH),
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

    logic             w_step_up;
    logic             w_step_down;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;
    logic             w_borrow;
    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            detector_flanco u_det_up (
                .clk     (clk),
                .reset   (reset),
                .i_in    (up),
                .o_pulse (w_step_up)
            );
            detector_flanco u_det_down (
                .clk     (clk),
                .reset   (reset),
                .i_in    (down),
                .o_pulse (w_step_down)
            );
        end else begin : g_level
            assign w_step_up   = up;
            assign w_step_down = down;
        end
    endgenerate

    // Load beats stepping; a count above MAX is treated as terminal so a wrap
    // step recovers it to zero.
    always_comb begin
        w_next   = r_count;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
        if (load) begin
            w_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en && (w_step_up != w_step_down)) begin
            if (w_step_up) begin
                if (r_count < MAX_V) begin
                    w_next = r_count + 1'b1;
                end else if (mode == MODE_WRAP) begin
                    w_next  = '0;
                    w_carry = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_next = r_count - 1'b1;
                end else if (mode == MODE_WRAP) begin
                    w_next   = MAX_V;
                    w_borrow = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_count  <= w_next;
            r_carry  <= w_carry;
            r_borrow <= w_borrow;
        end
    end

    assign count  = r_count;
    assign carry  = r_carry;
    assign borrow = r_borrow;
    assign at_max = (r_count == MAX_V);
    assign at_min = (r_count == '0);

endmodule

// File: tb/tb_contador_updown_param.sv
// Randomised and directed bench for contador_updown_param: one edge-mode and
// one level-mode instance share inputs and are tracked by an arithmetic model.
module tb_contador_updown_param;

   localparam int MAXV = 9;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up;
   logic       down;
   logic       load;
   logic [3:0] loadVal;
   logic       mode;

   logic [3:0] eCount;
   logic       eCarry, eBorrow, eAtMax, eAtMin;
   logic [3:0] lCount;
   logic       lCarry, lBorrow, lAtMax, lAtMin;

   int checks   = 0;
   int failures = 0;

   // Model state: counter values, registered pulses and per-edge input samples.
   int mE, mL;
   bit mECarry, mEBorrow, mLCarry, mLBorrow;
   bit hU[3];
   bit hD[3];

   contador_updown_param #(.WIDTH(4), .MAX(MAXV), .EDGE_MODE(1)) dutEdge (
      .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
      .load_val(loadVal), .mode(mode), .count(eCount), .carry(eCarry),
      .borrow(eBorrow), .at_max(eAtMax), .at_min(eAtMin));

   contador_updown_param #(.WIDTH(4), .MAX(MAXV), .EDGE_MODE(0)) dutLevel (
      .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
      .load_val(loadVal), .mode(mode), .count(lCount), .carry(lCarry),
      .borrow(lBorrow), .at_max(lAtMax), .at_min(lAtMin));

   always #5 clk = ~clk;

   // Counter rules expressed as plain integer arithmetic.
   function automatic void refStep(input int cnt, input bit ld, input int lv, input bit e,
                                   input bit su, input bit sd, input bit md,
                                   output int nc, output bit ca, output bit bo);
      nc = cnt;
      ca = 1'b0;
      bo = 1'b0;
      if (ld) nc = (lv > MAXV) ? MAXV : lv;
      else if (e && su && !sd) begin
         if (cnt < MAXV) nc = cnt + 1;
         else if (!md) begin nc = 0; ca = 1'b1; end
      end else if (e && sd && !su) begin
         if (cnt > 0) nc = cnt - 1;
         else if (!md) begin nc = MAXV; bo = 1'b1; end
      end
   endfunction

   task automatic zeroModel();
      mE = 0; mL = 0;
      mECarry = 0; mEBorrow = 0; mLCarry = 0; mLBorrow = 0;
      for (int i = 0; i < 3; i++) begin hU[i] = 0; hD[i] = 0; end
   endtask

   // Advance one clock: update the model from the pre-edge inputs, then sample #1 after the edge.
   task automatic tick();
      int nc;
      bit ca, bo, su, sd;
      if (!reset) zeroModel();
      else begin
         su = hU[1] & ~hU[2];
         sd = hD[1] & ~hD[2];
         refStep(mE, load, int'(loadVal), en, su, sd, mode, nc, ca, bo);
         mE = nc; mECarry = ca; mEBorrow = bo;
         refStep(mL, load, int'(loadVal), en, up, down, mode, nc, ca, bo);
         mL = nc; mLCarry = ca; mLBorrow = bo;
         hU[2] = hU[1]; hU[1] = hU[0]; hU[0] = up;
         hD[2] = hD[1]; hD[1] = hD[0]; hD[0] = down;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic loadBoth(input logic [3:0] v);
      loadVal = v; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (eCount !== 4'd0 || eCarry !== 1'b0 || eBorrow !== 1'b0 || eAtMin !== 1'b1 || eAtMax !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state_edge count=%0d c=%b b=%b min=%b max=%b, required 0 0 0 1 0",
                  eCount, eCarry, eBorrow, eAtMin, eAtMax);
      end
      checks++;
      if (lCount !== 4'd0 || lAtMin !== 1'b1 || lAtMax !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state_level count=%0d min=%b max=%b, required 0 1 0", lCount, lAtMin, lAtMax);
      end
      loadBoth(4'd5);
      checks++;
      if (eCount !== 4'd5) begin
         failures++;
         $display("[TB] FAIL load_before_reset count=%0d required 5", eCount);
      end
      #2 reset = 1'b0;
      zeroModel();
      #1;
      checks++;
      if (eCount !== 4'd0 || lCount !== 4'd0 || eAtMin !== 1'b1 || eAtMax !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset edge=%0d level=%0d min=%b max=%b, required 0 0 1 0",
                  eCount, lCount, eAtMin, eAtMax);
      end
      up = 1'b1;
      tick(); tick();
      up = 1'b0;
      tick();
      #2 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (eCount !== 4'd0 || lCount !== 4'd0 || eCarry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_step_after_reset cycle=%0d edge=%0d level=%0d, required 0 0", i, eCount, lCount);
         end
      end
   endtask

   task automatic test_edge_latency_carry();
      int nCarry = 0;
      mode = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (eCount !== ((i >= 3) ? 4'd1 : 4'd0)) begin
            failures++;
            $display("[TB] FAIL held_up_one_step cycle=%0d count=%0d required %0d", i, eCount, (i >= 3) ? 1 : 0);
         end
      end
      up = 1'b0;
      tick(); tick(); tick();
      for (int p = 0; p < 10; p++) begin
         up = 1'b1;
         tick();
         up = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checks++;
            if (eCount !== 4'(mE) || eCarry !== mECarry) begin
               failures++;
               $display("[TB] FAIL pulse_count pulse=%0d count=%0d carry=%b, required %0d %b",
                        p, eCount, eCarry, mE, mECarry);
            end
            if (eCarry) nCarry++;
         end
      end
      checks++;
      if (nCarry != 1 || eCount !== 4'd1) begin
         failures++;
         $display("[TB] FAIL carry_once carries=%0d final=%0d, required 1 1", nCarry, eCount);
      end
   endtask

   task automatic test_borrow();
      int nBorrow = 0;
      loadBoth(4'd0);
      mode = 1'b0; en = 1'b1;
      down = 1'b1; tick(); down = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (eBorrow) begin
            nBorrow++;
            checks++;
            if (eCount !== 4'd9) begin
               failures++;
               $display("[TB] FAIL borrow_alignment count=%0d required 9", eCount);
            end
         end
      end
      checks++;
      if (nBorrow != 1 || eCount !== 4'd9) begin
         failures++;
         $display("[TB] FAIL wrap_borrow borrows=%0d count=%0d, required 1 9", nBorrow, eCount);
      end
      loadBoth(4'd0);
      mode = 1'b1; nBorrow = 0;
      down = 1'b1; tick(); down = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (eBorrow) nBorrow++;
      end
      checks++;
      if (nBorrow != 0 || eCount !== 4'd0 || eAtMin !== 1'b1) begin
         failures++;
         $display("[TB] FAIL sat_down borrows=%0d count=%0d min=%b, required 0 0 1", nBorrow, eCount, eAtMin);
      end
   endtask

   task automatic test_saturate_up();
      loadBoth(4'd9);
      mode = 1'b1; en = 1'b1;
      up = 1'b1; tick(); up = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (eCount !== 4'd9 || eCarry !== 1'b0 || eAtMax !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_up cycle=%0d count=%0d carry=%b max=%b, required 9 0 1", k, eCount, eCarry, eAtMax);
         end
      end
   endtask

   task automatic test_load_priority();
      loadBoth(4'd13);
      checks++;
      if (eCount !== 4'd9 || lCount !== 4'd9) begin
         failures++;
         $display("[TB] FAIL load_clamp edge=%0d level=%0d, required 9 9", eCount, lCount);
      end
      mode = 1'b0; en = 1'b1;
      up = 1'b1; tick(); up = 1'b0; tick();
      loadVal = 4'd3; load = 1'b1; tick(); load = 1'b0;
      checks++;
      if (eCount !== 4'd3) begin
         failures++;
         $display("[TB] FAIL load_beats_edge_step count=%0d required 3", eCount);
      end
      loadVal = 4'd6; load = 1'b1; up = 1'b1; tick(); load = 1'b0; up = 1'b0;
      checks++;
      if (lCount !== 4'd6) begin
         failures++;
         $display("[TB] FAIL load_beats_level_step count=%0d required 6", lCount);
      end
      tick(); tick(); tick();
      loadBoth(4'd4);
      tick(); tick(); tick();
      up = 1'b1; down = 1'b1; tick(); up = 1'b0; down = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (eCount !== 4'd4 || lCount !== 4'd4) begin
         failures++;
         $display("[TB] FAIL up_down_hold edge=%0d level=%0d, required 4 4", eCount, lCount);
      end
   endtask

   task automatic test_level_mode();
      loadBoth(4'd0);
      en = 1'b1; mode = 1'b0; up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         checks++;
         if (lCount !== 4'(i % 10) || lCarry !== (i == 10)) begin
            failures++;
            $display("[TB] FAIL level_count cycle=%0d count=%0d carry=%b, required %0d %b",
                     i, lCount, lCarry, i % 10, i == 10);
         end
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (lCount !== 4'd2 || lCarry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_freeze cycle=%0d count=%0d required 2", i, lCount);
         end
      end
      up = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(0, 7) != 0);
         up      = $urandom_range(0, 1);
         down    = ($urandom_range(0, 3) == 0);
         load    = ($urandom_range(0, 15) == 0);
         loadVal = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         tick();
         checks++;
         if (eCount !== 4'(mE) || eCarry !== mECarry || eBorrow !== mEBorrow ||
             eAtMax !== (mE == MAXV) || eAtMin !== (mE == 0)) begin
            failures++;
            $display("[TB] FAIL random_edge cycle=%0d count=%0d c=%b b=%b, required %0d %b %b",
                     i, eCount, eCarry, eBorrow, mE, mECarry, mEBorrow);
         end
         checks++;
         if (lCount !== 4'(mL) || lCarry !== mLCarry || lBorrow !== mLBorrow ||
             lAtMax !== (mL == MAXV) || lAtMin !== (mL == 0)) begin
            failures++;
            $display("[TB] FAIL random_level cycle=%0d count=%0d c=%b b=%b, required %0d %b %b",
                     i, lCount, lCarry, lBorrow, mL, mLCarry, mLBorrow);
         end
      end
      load = 1'b0; up = 1'b0; down = 1'b0;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0;
      load = 1'b0; loadVal = 4'd0; mode = 1'b0;
      zeroModel();
      #12 reset = 1'b1;
      en = 1'b1;
      test_reset();
      test_edge_latency_carry();
      test_borrow();
      test_saturate_up();
      test_load_priority();
      test_level_mode();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
